// File: rtl/vdmem_pkg.sv
// Shared types and defaults for the vector data memory and its dump engine.
// Switch index constants name the board switch bits as seen through the MMIO window.
package vdmem_pkg;

   localparam int VD_W         = 32;
   localparam int VD_LANES     = 6;
   localparam int VD_MMIO_BASE = 30000;

   localparam int SW_RED0   = 0;
   localparam int SW_RED1   = 1;
   localparam int SW_GREEN0 = 2;
   localparam int SW_GREEN1 = 3;
   localparam int SW_BLUE0  = 4;
   localparam int SW_BLUE1  = 5;
   localparam int SW_TRAN0  = 6;
   localparam int SW_TRAN1  = 7;
   localparam int SW_GTYPE  = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } dump_state_t;

endpackage

// File: rtl/vdmem_dump_ctrl.sv
// Dump engine: walks the array, one word per grant; word shows 1 cycle after its fetch.
// Backpressure: the word is held stable until dump_ready; no fetch while a word is held.
module vdmem_dump_ctrl
   import vdmem_pkg::*;
#(
   parameter int W     = VD_W,
   parameter int DEPTH = 30015,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          dump_start,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   input  logic          rd_gnt,
   input  logic [W-1:0]  rd_data,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic [AW-1:0] dump_addr,
   output logic [W-1:0]  dump_data,
   output logic          dump_busy,
   output logic          dump_done
);

   dump_state_t   state;
   logic          start_q;
   logic [AW-1:0] ptr;

   assign rd_req  = (state == RUN) && !dump_valid;
   assign rd_addr = ptr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         ptr        <= '0;
         dump_valid <= 1'b0;
         dump_addr  <= '0;
         dump_data  <= '0;
         dump_busy  <= 1'b0;
         dump_done  <= 1'b0;
      end else begin
         start_q   <= dump_start;
         dump_done <= 1'b0;
         case (state)
            IDLE: begin
               if (dump_start && !start_q) begin
                  state     <= RUN;
                  ptr       <= '0;
                  dump_busy <= 1'b1;
               end
            end
            RUN: begin
               if (dump_valid) begin
                  if (dump_ready) begin
                     dump_valid <= 1'b0;
                     ptr        <= ptr + 1'b1;
                     if (ptr == AW'(DEPTH - 1)) begin
                        state     <= DONE;
                        dump_busy <= 1'b0;
                        dump_done <= 1'b1;
                     end
                  end
               end else if (rd_gnt) begin
                  dump_valid <= 1'b1;
                  dump_addr  <= ptr;
                  dump_data  <= rd_data;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/vdmem_ram.sv
// Masked multi-lane data memory with switch MMIO window and hardware dump port.
// Reads return 1 cycle after request; core access always wins over dump fetches.
module vdmem_ram
   import vdmem_pkg::*;
#(
   parameter int W         = VD_W,
   parameter int LANES     = VD_LANES,
   parameter int DEPTH     = 30015,
   parameter int AW        = 32,
   parameter int MMIO_BASE = VD_MMIO_BASE,
   parameter int SW_BITS   = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   input  logic               we,
   input  logic               is_vector,
   input  logic [AW-1:0]      address,
   input  logic [LANES-1:0]   lane_mask,
   input  logic [W*LANES-1:0] wd,
   output logic [W*LANES-1:0] rd,
   output logic               rd_valid,
   output logic               addr_err,
   input  logic [SW_BITS-1:0] sw_in,
   input  logic               dump_start,
   output logic               dump_valid,
   input  logic               dump_ready,
   output logic [AW-1:0]      dump_addr,
   output logic [W-1:0]       dump_data,
   output logic               dump_busy,
   output logic               dump_done
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]             mem [DEPTH];
   logic [SW_BITS-1:0]       sw_sync1, sw_sync2;
   logic [LANES-1:0]         lane_en, lane_oob;
   logic [LANES-1:0][AW:0]   lane_addr;
   logic [W*LANES-1:0]       rd_next;
   logic                     dump_rd_req;
   logic [AW-1:0]            dump_rd_addr;
   logic [W-1:0]             dump_word;

   function automatic logic in_window(input logic [AW:0] a);
      return (a >= (AW+1)'(MMIO_BASE)) && (a < (AW+1)'(MMIO_BASE + SW_BITS));
   endfunction

   // Lane addresses carry one extra bit so an overflowing address reads as out of range.
   function automatic logic [W-1:0] word_at(input logic [AW:0] a);
      word_at = '0;
      if (in_window(a))
         word_at = W'(sw_sync2 >> (a - (AW+1)'(MMIO_BASE))) & W'(1);
      else if (a < (AW+1)'(DEPTH))
         word_at = mem[a[IW-1:0]];
   endfunction

   always_comb begin
      lane_en   = is_vector ? lane_mask : LANES'(1);
      lane_addr = '0;
      lane_oob  = '0;
      rd_next   = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_addr[i] = {1'b0, address} + (AW+1)'(i);
         lane_oob[i]  = lane_en[i] && (lane_addr[i] >= (AW+1)'(DEPTH));
         if (lane_en[i] && !lane_oob[i])
            rd_next[i*W +: W] = word_at(lane_addr[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (req_valid && we) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_en[i] && !lane_oob[i] && !in_window(lane_addr[i]))
               mem[lane_addr[i][IW-1:0]] <= wd[i*W +: W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd       <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
         sw_sync1 <= '0;
         sw_sync2 <= '0;
      end else begin
         sw_sync1 <= sw_in;
         sw_sync2 <= sw_sync1;
         rd_valid <= req_valid && !we;
         addr_err <= req_valid && (|lane_oob);
         if (req_valid && !we)
            rd <= rd_next;
      end
   end

   assign dump_word = word_at({1'b0, dump_rd_addr});

   vdmem_dump_ctrl #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dump_ctrl (
      .clk        (clk),
      .rst_n      (rst_n),
      .dump_start (dump_start),
      .rd_req     (dump_rd_req),
      .rd_addr    (dump_rd_addr),
      .rd_gnt     (dump_rd_req && !req_valid),
      .rd_data    (dump_word),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy),
      .dump_done  (dump_done)
   );

endmodule

// File: doc/vdmem_ram.md
Name: vdmem_ram

Overview:
- Parametrised vector/scalar data memory for the vector processor datapath; successor to the single-lane data RAM.
- Adds masked multi-lane access, a registered 1-cycle read path, per-lane address checking, and a synchronised read-only switch MMIO window.
- Adds a hardware dump engine that streams the whole array over a valid/ready port to the image-output logic, replacing simulation-only dumping.

Parameters:
- W, 32, word width in bits
- LANES, 6, words per vector access
- DEPTH, 30015, words in array
- AW, 32, address width
- MMIO_BASE, 30000, first word of switch window
- SW_BITS, 9, switch inputs mapped one per word (MMIO_BASE+SW_BITS <= DEPTH)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  core access request this cycle
- we  in  1  1 = write, 0 = read
- is_vector  in  1  1 = LANES-word access, 0 = scalar (lane 0 only)
- address  in  AW  base word address
- lane_mask  in  LANES  per-lane enable, vector mode only
- wd  in  W*LANES  write data, lane i = wd[i*W +: W]
- rd  out  W*LANES  read data, lane i at address+i
- rd_valid  out  1  read data valid pulse
- addr_err  out  1  out-of-range lane in the previous request
- sw_in  in  SW_BITS  asynchronous board switches (red[1:0], green[1:0], blue[1:0], tran[1:0], gtype)
- dump_start  in  1  level; rising edge starts dump
- dump_valid  out  1  dump word available
- dump_ready  in  1  consumer accepts word
- dump_addr  out  AW  address of dump_data
- dump_data  out  W  dumped word
- dump_busy  out  1  dump in progress
- dump_done  out  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (rst_n=0 at clk edge):
  - rd, rd_valid, addr_err, all dump outputs, sync flops and start edge-detect cleared; FSM to IDLE.
  - Array contents not cleared; power-up contents zero.
- Lane enables:
  - Scalar: lane 0 enabled, lane_mask ignored.
  - Vector: lane i enabled iff lane_mask[i].
  - Lane address = address+i, computed in AW bits, no wrap.
- Write (req_valid & we):
  - Each enabled lane with addr < DEPTH and outside the MMIO window is written at this edge.
  - Writes into the window are silently dropped; no error.
- Read (req_valid & !we):
  - rd and rd_valid=1 registered at the next edge, i.e. 1-cycle latency; rd_valid otherwise 0.
  - Disabled or out-of-range lanes return 0.
  - Window word MMIO_BASE+k returns zero-extended sw_sync[k].
- Write followed by read of the same address in the next cycle returns the new data.
- addr_err: registered with the same timing as rd_valid, for reads and writes. Set iff any enabled lane address >= DEPTH; the other lanes still complete.
- Switches: sw_in passes through a two-flop synchroniser; the window reflects the second flop.
- Dump FSM:
  - IDLE -> RUN on the registered rising edge of dump_start; pointer = 0, dump_busy = 1.
  - RUN:
    - Internal read of the array at the pointer only in cycles with req_valid=0 and no word held; the word is presented 1 cycle later with dump_valid=1.
    - The word (dump_valid, dump_data, dump_addr) is held stable until dump_ready.
    - On handshake the pointer increments; if the pointer was DEPTH-1, go to DONE.
  - DONE: dump_done=1 and dump_busy=0 for one cycle, then IDLE.
  - dump_start edges while RUN/DONE are ignored.
  - Core requests always win the array port. Core writes during a dump are allowed; a word reflects array contents at its fetch cycle.
  - The MMIO window is dumped with live switch values.
  - Reset mid-dump aborts immediately; no dump_done.

Decomposition:
- Package vdmem_pkg:
  - dump_state_t enum {IDLE, RUN, DONE}
  - default W/LANES/MMIO_BASE constants
  - switch index constants (SW_RED0 = 0 ... SW_GTYPE = 8)
- Sub-module vdmem_dump_ctrl: dump FSM, pointer and output hold register. It requests array reads through a req/grant pair from the top.

Test Plan:
- Vector write: address=100, mask=6'b111111, wd lanes = 0xA0..0xA5; read next cycle -> rd lanes 0xA0..0xA5, rd_valid high exactly 1 cycle after request.
- Masked/scalar:
  - Vector write address=200, mask=6'b000101, lanes=1..6 -> words 200=1, 202=3, others unchanged 0.
  - Scalar write address=300, wd=0x55 -> only word 300 = 0x55.
- Range error:
  - Vector read address=DEPTH-3, full mask -> lanes 0..2 valid, lanes 3..5 = 0, addr_err=1 for one cycle.
  - Write of 0x7 to MMIO_BASE+2 is dropped, addr_err=0.
- Switches: sw_in=9'b1_0100_1001 -> after 2 edges, reads of 30000..30008 return 1,0,0,1,0,0,1,0,1.
- Dump with DEPTH=16 override, preload word i = i*3:
  - Pulse dump_start; dump_ready toggling 50%; core read every 3rd cycle.
  - Expect 16 words at addresses 0..15, data i*3, in order, stable while stalled; dump_done single pulse; no further words.
- Reset mid-dump (rst_n=0 after 5 words) -> dump_valid/busy=0 next edge, no dump_done; a new dump_start restarts at address 0.
